// File: rtl/coeff_bank_loader.sv
// Streams NUM_TAPS coefficients from a local FIFO into an idle filter bank that is not in use,
// then optionally switches that axis over to the freshly loaded bank.
module coeff_bank_loader #(
  parameter int NUM_TAPS   = 32,
  parameter int COEFF_W    = 17,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          i_sys_clk,
  input  logic                          i_rst,
  input  logic                          i_coeff_wr,
  input  logic [COEFF_W-1:0]            i_coeff_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_fifo_ovf,
  input  logic                          i_cmd_start,
  input  logic [1:0]                    i_cmd_axis,
  input  logic [1:0]                    i_cmd_bank,
  input  logic                          i_cmd_swap,
  input  logic                          i_filter_busy,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_update_en,
  output logic [1:0]                    o_update_axis,
  output logic [1:0]                    o_update_bank,
  output logic [$clog2(NUM_TAPS)-1:0]   o_update_index,
  output logic [COEFF_W-1:0]            o_update_value,
  output logic [1:0]                    o_x_bank,
  output logic [1:0]                    o_y_bank,
  output logic [1:0]                    o_z_bank
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_SWAP, S_FIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [COEFF_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic [1:0]         r_axis, r_bank;
  logic               r_swap;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_err, r_done;
  logic               r_upd_en;
  logic [1:0]         r_upd_axis, r_upd_bank;
  logic [IDX_W-1:0]   r_upd_index;
  logic [COEFF_W-1:0] r_upd_value;
  logic [1:0]         r_x_bank, r_y_bank, r_z_bank;

  logic       w_full, w_empty, w_push, w_pop;
  logic       w_start, w_err_nxt, w_done_nxt, w_swap_now;
  logic [1:0] w_active_bank;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_coeff_wr && !w_full;

  always_ff @(posedge i_sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_coeff_data;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (i_coeff_wr && w_full) r_ovf <= 1'b1;
      else if (w_start)         r_ovf <= 1'b0;
    end
  end

  always_comb begin
    case (r_axis)
      2'd0:    w_active_bank = r_x_bank;
      2'd1:    w_active_bank = r_y_bank;
      2'd2:    w_active_bank = r_z_bank;
      default: w_active_bank = 2'd0;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pop       = 1'b0;
    w_err_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_swap_now  = 1'b0;
    case (r_state)
      S_IDLE: if (i_cmd_start) begin
        w_start     = 1'b1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Never overwrite the bank the filter is running on, and only start with a full set queued.
        if (r_axis == 2'd3 || r_bank == w_active_bank || r_count < CNT_W'(NUM_TAPS)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: if (!w_empty && !i_filter_busy) begin
        w_pop = 1'b1;
        if (r_cnt == LAST_IDX) w_state_nxt = r_swap ? S_SWAP : S_FIN;
      end
      S_SWAP: if (!i_filter_busy) begin
        w_swap_now  = 1'b1;
        w_state_nxt = S_FIN;
      end
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_axis      <= '0;
      r_bank      <= '0;
      r_swap      <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_upd_en    <= 1'b0;
      r_upd_axis  <= '0;
      r_upd_bank  <= '0;
      r_upd_index <= '0;
      r_upd_value <= '0;
      r_x_bank    <= '0;
      r_y_bank    <= '0;
      r_z_bank    <= '0;
    end else begin
      r_err    <= w_err_nxt;
      r_done   <= w_done_nxt;
      r_upd_en <= w_pop;
      if (w_start) begin
        r_axis <= i_cmd_axis;
        r_bank <= i_cmd_bank;
        r_swap <= i_cmd_swap;
      end
      if (r_state == S_CHECK) r_cnt <= '0;
      if (w_pop) begin
        r_upd_axis  <= r_axis;
        r_upd_bank  <= r_bank;
        r_upd_index <= r_cnt;
        r_upd_value <= r_mem[r_rd_ptr];
        r_cnt       <= r_cnt + IDX_W'(1);
      end
      if (w_swap_now) begin
        case (r_axis)
          2'd0:    r_x_bank <= r_bank;
          2'd1:    r_y_bank <= r_bank;
          default: r_z_bank <= r_bank;
        endcase
      end
    end
  end

  assign o_fifo_count   = r_count;
  assign o_fifo_ovf     = r_ovf;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_update_en    = r_upd_en;
  assign o_update_axis  = r_upd_axis;
  assign o_update_bank  = r_upd_bank;
  assign o_update_index = r_upd_index;
  assign o_update_value = r_upd_value;
  assign o_x_bank       = r_x_bank;
  assign o_y_bank       = r_y_bank;
  assign o_z_bank       = r_z_bank;

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Scenario bench for coeff_bank_loader against a queue-based model of the FIFO, banks and load timing.
module tb_coeff_bank_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coeff_wr = 1'b0;
  logic [16:0] coeff_data = '0;
  logic [5:0]  fifo_count;
  logic        fifo_ovf;
  logic        cmd_start = 1'b0;
  logic [1:0]  cmd_axis = '0;
  logic [1:0]  cmd_bank = '0;
  logic        cmd_swap = 1'b0;
  logic        filter_busy = 1'b0;
  logic        busy, done, err, upd_en;
  logic [1:0]  upd_axis, upd_bank;
  logic [4:0]  upd_index;
  logic [16:0] upd_value;
  logic [1:0]  x_bank, y_bank, z_bank;

  always #5 clk = ~clk;

  coeff_bank_loader #(.NUM_TAPS(32), .COEFF_W(17), .FIFO_DEPTH(32)) dut (
    .i_sys_clk(clk), .i_rst(rst), .i_coeff_wr(coeff_wr), .i_coeff_data(coeff_data),
    .o_fifo_count(fifo_count), .o_fifo_ovf(fifo_ovf),
    .i_cmd_start(cmd_start), .i_cmd_axis(cmd_axis), .i_cmd_bank(cmd_bank), .i_cmd_swap(cmd_swap),
    .i_filter_busy(filter_busy), .o_busy(busy), .o_done(done), .o_err(err),
    .o_update_en(upd_en), .o_update_axis(upd_axis), .o_update_bank(upd_bank),
    .o_update_index(upd_index), .o_update_value(upd_value),
    .o_x_bank(x_bank), .o_y_bank(y_bank), .o_z_bank(z_bank)
  );

  typedef struct {int cyc; logic [1:0] ax; logic [1:0] bk; logic [4:0] idx; logic [16:0] val;} wr_t;

  int         errors = 0;
  int         checks = 0;
  int         mq[$];
  logic [1:0] mbank [3];
  logic       movf;
  int         ev [32];
  wr_t        wq[$];

  // Cycle t counts from the negedge where cmd_start is raised; mode 1 keeps the filter busy on odd cycles.
  function automatic logic busy_at(int mode, int t);
    return (mode == 1) ? logic'(t % 2) : 1'b0;
  endfunction

  // Cycle on which the i-th write is decided: the i-th filter-idle cycle from cycle 2 onward.
  function automatic int idle_slot(int mode, int i);
    int n = -1;
    for (int t = 2; t < 1000; t++) begin
      if (!busy_at(mode, t)) n++;
      if (n == i) return t;
    end
    return -1;
  endfunction

  function automatic int exp_done(int mode, logic sw);
    int t = idle_slot(mode, 31) + 1;
    if (sw) begin
      while (busy_at(mode, t)) t++;
      t++;
    end
    return t + 1;
  endfunction

  function automatic logic model_rejects(logic [1:0] ax, logic [1:0] bk);
    if (ax == 2'd3) return 1'b1;
    if (bk == mbank[ax]) return 1'b1;
    return mq.size() < 32;
  endfunction

  task automatic model_reset();
    mq.delete();
    mbank[0] = 2'd0; mbank[1] = 2'd0; mbank[2] = 2'd0;
    movf = 1'b0;
  endtask

  task automatic model_take(logic [1:0] ax, logic [1:0] bk, logic sw);
    for (int i = 0; i < 32; i++) ev[i] = mq.pop_front();
    if (sw) mbank[ax] = bk;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push_vals(int n, bit seq);
    for (int i = 0; i < n; i++) begin
      coeff_wr   = 1'b1;
      coeff_data = seq ? 17'(i) : 17'($urandom_range(0, 131071));
      if (mq.size() < 32) mq.push_back(int'(coeff_data));
      else movf = 1'b1;
      @(negedge clk);
    end
    coeff_wr = 1'b0;
  endtask

  task automatic run_load(logic [1:0] ax, logic [1:0] bk, logic sw, int mode,
                          output int done_c, output int err_c, output logic ovf1);
    wq.delete();
    done_c = -1; err_c = -1; ovf1 = 1'bx;
    cmd_axis = ax; cmd_bank = bk; cmd_swap = sw; cmd_start = 1'b1;
    movf = 1'b0;
    filter_busy = busy_at(mode, 0);
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (upd_en) wq.push_back('{t, upd_axis, upd_bank, upd_index, upd_value});
      if (t == 1) ovf1 = fifo_ovf;
      if (done && done_c < 0) done_c = t;
      if (err && err_c < 0) err_c = t;
      filter_busy = busy_at(mode, t);
      if (done_c >= 0 || err_c >= 0) break;
    end
    filter_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++; if (fifo_count !== 6'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if ({fifo_ovf, busy, done, err, upd_en} !== 5'd0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {fifo_ovf, busy, done, err, upd_en}); end
    checks++; if ({upd_axis, upd_bank, upd_index, upd_value} !== 26'd0) begin errors++; $display("FAIL reset_update: got %h expected 0", {upd_axis, upd_bank, upd_index, upd_value}); end
    checks++; if ({x_bank, y_bank, z_bank} !== 6'd0) begin errors++; $display("FAIL reset_banks: got %b expected 000000", {x_bank, y_bank, z_bank}); end
  endtask

  task automatic test_swap_load();
    int dc, ec; logic o1;
    push_vals(32, 1'b1);
    checks++; if (fifo_count !== 6'(mq.size())) begin errors++; $display("FAIL swap_prefill_count: got %0d expected %0d", fifo_count, mq.size()); end
    model_take(2'd1, 2'd2, 1'b1);
    run_load(2'd1, 2'd2, 1'b1, 0, dc, ec, o1);
    checks++; if (wq.size() != 32) begin errors++; $display("FAIL swap_write_count: got %0d expected 32", wq.size()); end
    for (int i = 0; i < wq.size() && i < 32; i++) begin
      checks++;
      if ({wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk} !== {5'(i), 17'(ev[i]), 2'd1, 2'd2}) begin
        errors++; $display("FAIL swap_write %0d: got idx=%0d val=%0d ax=%0d bk=%0d expected idx=%0d val=%0d ax=1 bk=2", i, wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk, i, ev[i]);
      end
      checks++; if (wq[i].cyc != idle_slot(0, i) + 1) begin errors++; $display("FAIL swap_write_cycle %0d: got %0d expected %0d", i, wq[i].cyc, idle_slot(0, i) + 1); end
    end
    checks++; if (dc != exp_done(0, 1'b1) || ec != -1) begin errors++; $display("FAIL swap_done_cycle: got done=%0d err=%0d expected done=%0d err=-1", dc, ec, exp_done(0, 1'b1)); end
    checks++; if ({x_bank, y_bank, z_bank} !== {mbank[0], mbank[1], mbank[2]}) begin errors++; $display("FAIL swap_banks: got %b expected %b", {x_bank, y_bank, z_bank}, {mbank[0], mbank[1], mbank[2]}); end
    checks++; if (fifo_count !== 6'(mq.size()) || busy !== 1'b0) begin errors++; $display("FAIL swap_after: got count=%0d busy=%b expected count=%0d busy=0", fifo_count, busy, mq.size()); end
  endtask

  task automatic test_filter_busy();
    int dc, ec; logic o1;
    push_vals(32, 1'b0);
    model_take(2'd0, 2'd1, 1'b1);
    run_load(2'd0, 2'd1, 1'b1, 1, dc, ec, o1);
    checks++; if (wq.size() != 32) begin errors++; $display("FAIL fbusy_write_count: got %0d expected 32", wq.size()); end
    for (int i = 0; i < wq.size() && i < 32; i++) begin
      checks++;
      if ({wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk} !== {5'(i), 17'(ev[i]), 2'd0, 2'd1}) begin
        errors++; $display("FAIL fbusy_write %0d: got idx=%0d val=%0d ax=%0d bk=%0d expected idx=%0d val=%0d ax=0 bk=1", i, wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk, i, ev[i]);
      end
      checks++; if (wq[i].cyc != idle_slot(1, i) + 1) begin errors++; $display("FAIL fbusy_write_cycle %0d: got %0d expected %0d", i, wq[i].cyc, idle_slot(1, i) + 1); end
    end
    checks++; if (dc != exp_done(1, 1'b1)) begin errors++; $display("FAIL fbusy_done_cycle: got %0d expected %0d", dc, exp_done(1, 1'b1)); end
    checks++; if (x_bank !== mbank[0]) begin errors++; $display("FAIL fbusy_x_bank: got %0d expected %0d", x_bank, mbank[0]); end
  endtask

  task automatic test_reject();
    int dc, ec; logic o1;
    push_vals(32, 1'b0);
    run_load(2'd0, mbank[0], 1'b1, 0, dc, ec, o1);
    checks++; if (ec != 2 || dc != -1 || wq.size() != 0) begin errors++; $display("FAIL reject_same_bank: got err=%0d done=%0d writes=%0d expected err=2 done=-1 writes=0", ec, dc, wq.size()); end
    checks++; if (fifo_count !== 6'(mq.size())) begin errors++; $display("FAIL reject_same_bank_count: got %0d expected %0d", fifo_count, mq.size()); end
    run_load(2'd3, 2'd2, 1'b0, 0, dc, ec, o1);
    checks++; if (ec != 2 || dc != -1 || wq.size() != 0) begin errors++; $display("FAIL reject_axis3: got err=%0d done=%0d writes=%0d expected err=2 done=-1 writes=0", ec, dc, wq.size()); end
    checks++; if (fifo_count !== 6'(mq.size()) || busy !== 1'b0) begin errors++; $display("FAIL reject_axis3_after: got count=%0d busy=%b expected count=%0d busy=0", fifo_count, busy, mq.size()); end
  endtask

  task automatic test_short_fifo();
    int dc, ec; logic o1;
    do_reset();
    push_vals(10, 1'b0);
    run_load(2'd1, 2'd1, 1'b0, 0, dc, ec, o1);
    checks++; if (ec != 2 || wq.size() != 0) begin errors++; $display("FAIL short_fifo_err: got err=%0d writes=%0d expected err=2 writes=0", ec, wq.size()); end
    checks++; if (fifo_count !== 6'(mq.size())) begin errors++; $display("FAIL short_fifo_count: got %0d expected %0d", fifo_count, mq.size()); end
  endtask

  task automatic test_overflow();
    int dc, ec; logic o1;
    do_reset();
    push_vals(33, 1'b0);
    checks++; if (fifo_count !== 6'(mq.size()) || fifo_ovf !== movf) begin errors++; $display("FAIL ovf_fill: got count=%0d ovf=%b expected count=%0d ovf=%b", fifo_count, fifo_ovf, mq.size(), movf); end
    model_take(2'd2, 2'd3, 1'b0);
    run_load(2'd2, 2'd3, 1'b0, 0, dc, ec, o1);
    checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", o1); end
    checks++; if (wq.size() != 32) begin errors++; $display("FAIL ovf_write_count: got %0d expected 32", wq.size()); end
    for (int i = 0; i < wq.size() && i < 32; i++) begin
      checks++;
      if ({wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk} !== {5'(i), 17'(ev[i]), 2'd2, 2'd3}) begin
        errors++; $display("FAIL ovf_write %0d: got idx=%0d val=%0d ax=%0d bk=%0d expected idx=%0d val=%0d ax=2 bk=3", i, wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk, i, ev[i]);
      end
    end
    checks++; if (dc != exp_done(0, 1'b0) || z_bank !== mbank[2]) begin errors++; $display("FAIL ovf_done: got done=%0d z_bank=%0d expected done=%0d z_bank=%0d", dc, z_bank, exp_done(0, 1'b0), mbank[2]); end
  endtask

  task automatic test_reset_mid();
    int dc, ec; logic o1; bit hit = 1'b0;
    push_vals(32, 1'b0);
    cmd_axis = 2'd2; cmd_bank = mbank[2] + 2'd1; cmd_swap = 1'b1; cmd_start = 1'b1;
    for (int t = 1; t <= 100 && !hit; t++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (upd_en && upd_index == 5'd15) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach: got no write at index 15 expected one within 100 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({busy, upd_en, fifo_count, x_bank, y_bank, z_bank} !== 14'd0) begin
      errors++; $display("FAIL rst_mid_state: got busy=%b en=%b count=%0d banks=%b expected all 0", busy, upd_en, fifo_count, {x_bank, y_bank, z_bank});
    end
    push_vals(32, 1'b0);
    model_take(2'd2, 2'd1, 1'b1);
    run_load(2'd2, 2'd1, 1'b1, 0, dc, ec, o1);
    checks++; if (wq.size() != 32 || dc != exp_done(0, 1'b1) || z_bank !== mbank[2]) begin errors++; $display("FAIL rst_mid_reload: got writes=%0d done=%0d z=%0d expected writes=32 done=%0d z=%0d", wq.size(), dc, z_bank, exp_done(0, 1'b1), mbank[2]); end
    for (int i = 0; i < wq.size() && i < 32; i++) begin
      checks++; if (wq[i].val !== 17'(ev[i]) || wq[i].idx !== 5'(i)) begin errors++; $display("FAIL rst_mid_write %0d: got idx=%0d val=%0d expected idx=%0d val=%0d", i, wq[i].idx, wq[i].val, i, ev[i]); end
    end
  endtask

  task automatic test_random();
    int dc, ec, n, mode; logic o1, rej, sw; logic [1:0] ax, bk;
    for (int it = 0; it < 8; it++) begin
      n    = $urandom_range(0, 40);
      ax   = 2'($urandom_range(0, 3));
      bk   = 2'($urandom_range(0, 3));
      sw   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 1);
      push_vals(n, 1'b0);
      checks++; if (fifo_ovf !== movf) begin errors++; $display("FAIL rand_ovf %0d: got %b expected %b", it, fifo_ovf, movf); end
      rej = model_rejects(ax, bk);
      if (!rej) model_take(ax, bk, sw);
      run_load(ax, bk, sw, mode, dc, ec, o1);
      if (rej) begin
        checks++; if (ec != 2 || wq.size() != 0) begin errors++; $display("FAIL rand_reject %0d: got err=%0d writes=%0d expected err=2 writes=0", it, ec, wq.size()); end
      end else begin
        checks++; if (ec != -1 || wq.size() != 32 || dc != exp_done(mode, sw)) begin errors++; $display("FAIL rand_load %0d: got err=%0d writes=%0d done=%0d expected err=-1 writes=32 done=%0d", it, ec, wq.size(), dc, exp_done(mode, sw)); end
        for (int i = 0; i < wq.size() && i < 32; i++) begin
          checks++;
          if ({wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk} !== {5'(i), 17'(ev[i]), ax, bk}) begin
            errors++; $display("FAIL rand_write %0d.%0d: got idx=%0d val=%0d ax=%0d bk=%0d expected idx=%0d val=%0d ax=%0d bk=%0d", it, i, wq[i].idx, wq[i].val, wq[i].ax, wq[i].bk, i, ev[i], ax, bk);
          end
        end
      end
      checks++; if ({x_bank, y_bank, z_bank} !== {mbank[0], mbank[1], mbank[2]} || fifo_count !== 6'(mq.size())) begin
        errors++; $display("FAIL rand_state %0d: got banks=%b count=%0d expected banks=%b count=%0d", it, {x_bank, y_bank, z_bank}, fifo_count, {mbank[0], mbank[1], mbank[2]}, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_swap_load();
    test_filter_busy();
    test_reject();
    test_short_fifo();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
